// File: rtl/fifo_top_gen_pkg.sv
// Shared types and constants for the FIFO traffic generator/checker.
`timescale 1ns/100ps
package fifo_top_gen_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  // Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    RST_PULSE,
    FILL,
    DRAIN,
    MIX,
    FLUSH,
    DONE
  } gen_state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] value);
    return {^(value & LFSR_TAPS), value[15:1]};
  endfunction

endpackage

// File: rtl/fifo_ref_model.sv
// Reference queue mirroring the FIFO under test; pop_data is registered like the FIFO read port.
`timescale 1ns/100ps
module fifo_ref_model
  import fifo_top_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic [DATA_WIDTH-1:0] pop_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
        pop_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_top_gen.sv
// Self-contained traffic generator and checker for a synchronous FIFO:
// resets it, fills, drains, runs LFSR-driven mixed traffic, flushes and reports pass/fail.
`timescale 1ns/100ps
module fifo_top_gen
  import fifo_top_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MIX_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  rst,
  output logic                  wr_cs,
  output logic                  wr_en,
  output logic                  rd_cs,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic                  full,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int MCW   = $clog2(MIX_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH - 1);

  gen_state_t            state;
  gen_state_t            state_next;
  logic [1:0]            pulse_cnt;
  logic [MCW-1:0]        mix_cnt;
  logic [15:0]           lfsr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_q;
  logic                  wr;
  logic                  rd;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  model_full;
  logic                  model_empty;
  logic [1:0]            miss;
  logic [8:0]            err_sum;

  fifo_ref_model #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_model (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == RST_PULSE),
    .push     (wr),
    .pop      (rd),
    .push_data(wr_data),
    .count    (count),
    .pop_data (pop_data)
  );

  assign model_full  = (count == CNT_FULL);
  assign model_empty = (count == '0);

  // Requests are gated by the model count, so the FIFO is never overrun or underrun.
  always_comb begin
    state_next = state;
    wr         = 1'b0;
    rd         = 1'b0;
    case (state)
      RST_PULSE: if (pulse_cnt == 2'd3) state_next = FILL;
      FILL:      if (model_full) state_next = DRAIN; else wr = 1'b1;
      DRAIN:     if (model_empty) state_next = MIX; else rd = 1'b1;
      MIX: begin
        wr = lfsr[0] & ~model_full;
        rd = lfsr[1] & ~model_empty;
        if (mix_cnt == MCW'(MIX_CYCLES - 1)) state_next = FLUSH;
      end
      FLUSH:     if (model_empty) state_next = DONE; else rd = 1'b1;
      DONE:      state_next = DONE;
      default:   state_next = RST_PULSE;
    endcase
  end

  assign rst     = (state == RST_PULSE);
  assign wr_cs   = wr;
  assign wr_en   = wr;
  assign rd_cs   = rd;
  assign rd_en   = rd;
  assign data_in = wr_data;
  assign done    = (state == DONE);
  assign pass    = done & (err_cnt == 8'h00);

  // Flags are compared against the count as it stood after the previous edge.
  assign miss    = {1'b0, rd_q & (data_out != pop_data)}
                 + {1'b0, full != model_full}
                 + {1'b0, empty != model_empty};
  assign err_sum = {1'b0, err_cnt} + {7'b0, miss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_PULSE;
      pulse_cnt <= '0;
      mix_cnt   <= '0;
      lfsr      <= LFSR_SEED;
      wr_data   <= '0;
      rd_q      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state <= state_next;
      rd_q  <= rd;
      if (state == RST_PULSE) pulse_cnt <= pulse_cnt + 2'd1;
      if (state == MIX) begin
        mix_cnt <= mix_cnt + MCW'(1);
        lfsr    <= lfsr_step(lfsr);
      end
      if (wr) wr_data <= wr_data + DATA_WIDTH'(1);
      if (state != RST_PULSE) err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_fifo_top_gen.sv
// Bench: fifo_top_gen driving a syn_fifo, checked cycle by cycle against a queue-based model.
`timescale 1ns/100ps
module tb_fifo_top_gen;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int MIXC  = 64;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          fault = 1'b0;
  logic          rst, wr_cs, wr_en, rd_cs, rd_en, full, empty, done, pass;
  logic [DW-1:0] data_in, fifo_dout, gen_dout;
  logic [7:0]    err_cnt;

  always #1 clk = ~clk;

  assign gen_dout = fifo_dout ^ {7'b0, fault};

  fifo_top_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MIX_CYCLES(MIXC)) dut (
    .clk(clk), .rst_n(rst_n), .rst(rst),
    .wr_cs(wr_cs), .wr_en(wr_en), .rd_cs(rd_cs), .rd_en(rd_en),
    .data_in(data_in), .full(full), .empty(empty), .data_out(gen_dout),
    .done(done), .pass(pass), .err_cnt(err_cnt)
  );

  syn_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_fifo (
    .clk(clk), .rst(rst),
    .wr_cs(wr_cs), .wr_en(wr_en), .rd_cs(rd_cs), .rd_en(rd_en),
    .data_in(data_in), .full(full), .empty(empty), .data_out(fifo_dout)
  );

  int errors = 0;
  int checks = 0;

  // Model: phase 0..5 = reset pulse, fill, drain, mix, flush, done.
  int          phase, pulse, mix, errs, drain_idx, s_n;
  logic [15:0] lf;
  logic [7:0]  wdata, last_pop;
  bit          rd_prev, s_wr, s_rd;
  logic [7:0]  q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = 0; pulse = 0; mix = 0; errs = 0; drain_idx = 0;
    lf = 16'hACE1; wdata = 8'h00; last_pop = 8'h00;
    rd_prev = 0; s_wr = 0; s_rd = 0; s_n = 0;
    q.delete();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rst"}, rst, 1);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_cs"}, wr_cs, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_cs"}, rd_cs, 0);
    check({tag, "_data_in"}, data_in, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  // Applies what the clock edge does to the model, using the decisions taken at the last sample.
  task automatic advance();
    if (rd_prev && fault) errs = (errs < 255) ? errs + 1 : 255;
    rd_prev = s_rd;
    if (s_rd) last_pop = q.pop_front();
    if (s_wr) begin q.push_back(wdata); wdata++; end
    case (phase)
      0: begin pulse++; if (pulse == 4) phase = 1; end
      1: if (s_n == DEPTH - 1) phase = 2;
      2: if (s_n == 0) phase = 3;
      3: begin
        lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
        mix++;
        if (mix == MIXC) phase = 4;
      end
      4: if (s_n == 0) phase = 5;
      default: ;
    endcase
  endtask

  task automatic compare();
    int  n;
    bit  e_wr, e_rd;
    if (!rst_n) begin
      model_reset();
      reset_checks("in_reset");
      return;
    end
    n = q.size(); e_wr = 0; e_rd = 0;
    case (phase)
      1: e_wr = (n != DEPTH - 1);
      2: e_rd = (n != 0);
      3: begin e_wr = lf[0] && (n != DEPTH - 1); e_rd = lf[1] && (n != 0); end
      4: e_rd = (n != 0);
      default: ;
    endcase
    check("wr_cs", wr_cs, e_wr);
    check("wr_en", wr_en, e_wr);
    check("rd_cs", rd_cs, e_rd);
    check("rd_en", rd_en, e_rd);
    check("rst", rst, phase == 0);
    check("done", done, phase == 5);
    check("pass", pass, (phase == 5) && (errs == 0));
    check("err_cnt", err_cnt, errs);
    if (e_wr) begin
      check("data_in", data_in, wdata);
      $display("write data=%02h count=%0d", data_in, n);
    end
    if (phase != 0) begin
      check("fifo_full", full, n == DEPTH - 1);
      check("fifo_empty", empty, n == 0);
    end
    if (rd_prev) begin
      check("fifo_data", fifo_dout, last_pop);
      $display("read  data=%02h expected=%02h err_cnt=%0d", fifo_dout, last_pop, err_cnt);
      if (phase == 2) begin
        check("drain_order", fifo_dout, drain_idx);
        drain_idx++;
      end
    end
    if (phase == 1 && n == DEPTH - 1) begin
      check("fill_full", full, 1);
      check("fill_empty", empty, 0);
      check("fill_err_cnt", err_cnt, 0);
    end
    if (phase == 2 && n == 0) check("drain_empty", empty, 1);
    if (wr_en) check("no_wr_when_full", full, 0);
    if (rd_en) check("no_rd_when_empty", empty, 0);
    s_wr = e_wr; s_rd = e_rd; s_n = n;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) advance(); else model_reset();
    @(negedge clk);
    compare();
  endtask

  task automatic run_to_done(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (phase == 5) break;
      step();
    end
    check({tag, "_reached_done"}, done, 1);
    repeat (3) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Run 1: correct FIFO.
    apply_reset();
    run_to_done("run1");
    check("run1_done", done, 1);
    check("run1_pass", pass, 1);
    check("run1_err_cnt", err_cnt, 0);

    // Run 2: FIFO read data bit0 inverted on its way back to the generator.
    fault = 1'b1;
    apply_reset();
    run_to_done("run2");
    check("run2_done", done, 1);
    check("run2_pass", pass, 0);
    check("run2_err_nonzero", err_cnt != 8'h00, 1);

    // Run 3: faulty start, then asynchronous reset in the middle of MIX with a clean FIFO.
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      if (phase == 3 && mix >= 20) break;
      step();
    end
    check("run3_in_mix_with_errors", err_cnt != 8'h00, 1);
    rst_n = 1'b0;
    fault = 1'b0;
    #0.5;
    reset_checks("async_abort");
    repeat (3) step();
    rst_n = 1'b1;
    run_to_done("run3");
    check("run3_done", done, 1);
    check("run3_pass", pass, 1);
    check("run3_err_cnt", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// Synchronous FIFO under test: one slot is kept spare, so full means DEPTH-1 entries.
module syn_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_cs,
  input  logic                  wr_en,
  input  logic                  rd_cs,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   status_cnt;
  logic                  wr_ok, rd_ok;

  assign full  = (status_cnt == (ADDR_WIDTH+1)'(DEPTH - 1));
  assign empty = (status_cnt == '0);
  assign wr_ok = wr_cs & wr_en & ~full;
  assign rd_ok = rd_cs & rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      status_cnt <= '0;
      data_out   <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
        data_out <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   status_cnt <= status_cnt + (ADDR_WIDTH+1)'(1);
        2'b01:   status_cnt <= status_cnt - (ADDR_WIDTH+1)'(1);
        default: status_cnt <= status_cnt;
      endcase
    end
  end

endmodule
